// File: rtl/ground.sv
// Scrolling ground layer for the VGA runner game: scroll offset, speed ramp
// and a registered ground pixel for the current (row, col) address.
module ground (
    input  logic [31:0] clkdiv,
    input  logic        N_rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        game_status,
    output logic [5:0]  ground_position,
    output logic [3:0]  speed,
    output logic        px
);

    localparam logic [3:0] SPEED_MAX = 4'd15;
    localparam logic [9:0] CNT_LAST  = 10'd1023;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == SPEED_MAX) ? SPEED_MAX : v + 4'd1;
    endfunction

    logic       clk;
    logic       unused_clkdiv_bits;
    logic       samp_q, samp_d;
    logic       prime_q, prime_d;
    logic [9:0] cnt_q, cnt_d;
    logic [5:0] pos_q, pos_d;
    logic [3:0] spd_q, spd_d;
    logic       px_q, px_d;
    logic       tick;
    logic [9:0] x_full;
    logic [5:0] x;
    logic       visible;

    assign clk                = clkdiv[0];
    assign unused_clkdiv_bits = ^{clkdiv[31:18], clkdiv[16:1]};

    // prime_q masks the first capture after reset so a high bit 17 is not
    // mistaken for a rising edge against the cleared sample register.
    always_comb begin
        tick   = prime_q && !samp_q && clkdiv[17];
        samp_d = clkdiv[17];
        prime_d = 1'b1;
        pos_d  = pos_q;
        spd_d  = spd_q;
        cnt_d  = cnt_q;
        if (tick && game_status) begin
            pos_d = pos_q + {2'b00, spd_q};
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == CNT_LAST) begin
                spd_d = sat_inc(spd_q);
            end
        end
    end

    always_comb begin
        x_full  = col_addr + {4'd0, pos_q};
        x       = x_full[5:0];
        visible = (col_addr < 10'd640) && (row_addr < 9'd480);
        px_d    = 1'b0;
        if (visible) begin
            case (row_addr)
                9'd400, 9'd401: px_d = 1'b1;
                9'd403:         px_d = (x[3:0] < 4'd3);
                9'd405:         px_d = (x[4:0] == 5'd20) || (x[4:0] == 5'd21);
                default:        px_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge N_rst) begin
        if (N_rst) begin
            samp_q  <= 1'b0;
            prime_q <= 1'b0;
            cnt_q   <= 10'd0;
            pos_q   <= 6'd0;
            spd_q   <= 4'd1;
            px_q    <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            prime_q <= prime_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            spd_q   <= spd_d;
            px_q    <= px_d;
        end
    end

    assign ground_position = pos_q;
    assign speed           = spd_q;
    assign px              = px_q;

endmodule

// File: tb/tb_ground.sv
// Scoreboard bench for ground: stimulus queues expected values, a monitor
// process pops and compares them when a check strobe or pixel valid arrives.
module tb_ground;

    typedef struct {
        int    kind;
        int    val;
        string nm;
    } chk_t;

    logic        clk;
    logic        b17;
    logic [31:0] clkdiv;
    logic        N_rst;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        game_status;
    logic [5:0]  ground_position;
    logic [3:0]  speed;
    logic        px;

    chk_t st_q[$];
    chk_t px_q[$];
    logic st_vld;
    logic addr_vld;
    logic vld_p1;
    int   n_checks;
    int   n_fail;

    assign clkdiv = {14'h2AAA, b17, 16'h5A5A, clk};

    ground dut (
        .clkdiv          (clkdiv),
        .N_rst           (N_rst),
        .row_addr        (row_addr),
        .col_addr        (col_addr),
        .game_status     (game_status),
        .ground_position (ground_position),
        .speed           (speed),
        .px              (px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic judge(input chk_t c, input int act);
        string what;
        what = (c.kind == 0) ? "ground_position" : (c.kind == 1) ? "speed" : "px";
        n_checks++;
        if (act != c.val) begin
            n_fail++;
            $display("FAIL %s %s: got %0d, want %0d", c.nm, what, act, c.val);
        end
    endtask

    always @(posedge clk) vld_p1 <= addr_vld;

    always @(negedge clk) begin
        chk_t c;
        if (st_vld) begin
            while (st_q.size() > 0) begin
                c = st_q.pop_front();
                case (c.kind)
                    0:       judge(c, int'(ground_position));
                    1:       judge(c, int'(speed));
                    default: judge(c, int'(px));
                endcase
            end
        end
        if (vld_p1) begin
            if (px_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL px_queue: got empty queue, want a pending entry");
            end else begin
                c = px_q.pop_front();
                judge(c, int'(px));
            end
        end
    end

    task automatic exp_state(input int p, input int s, input string nm);
        st_q.push_back('{kind: 0, val: p, nm: nm});
        st_q.push_back('{kind: 1, val: s, nm: nm});
        st_vld = 1'b1;
        @(negedge clk);
        #1 st_vld = 1'b0;
    endtask

    task automatic exp_px_now(input int e, input string nm);
        st_q.push_back('{kind: 2, val: e, nm: nm});
        st_vld = 1'b1;
        @(negedge clk);
        #1 st_vld = 1'b0;
    endtask

    // Address is replaced by a blank one right after the capturing edge, so a
    // combinational px would be seen at the compare point.
    task automatic px_chk(input int r, input int c, input int e, input string nm);
        @(posedge clk);
        #1;
        row_addr = 9'(r);
        col_addr = 10'(c);
        px_q.push_back('{kind: 2, val: e, nm: nm});
        addr_vld = 1'b1;
        @(posedge clk);
        #1;
        addr_vld = 1'b0;
        row_addr = 9'd0;
        col_addr = 10'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1 b17 = 1'b1;
        @(posedge clk);
        #1 b17 = 1'b0;
    endtask

    initial begin
        b17         = 1'b0;
        N_rst       = 1'b1;
        row_addr    = 9'd400;
        col_addr    = 10'd100;
        game_status = 1'b1;
        st_vld      = 1'b0;
        addr_vld    = 1'b0;
        n_checks    = 0;
        n_fail      = 0;

        repeat (3) @(posedge clk);
        exp_state(0, 1, "reset");
        exp_px_now(0, "reset_px");

        game_status = 1'b0;
        @(posedge clk);
        #1 N_rst = 1'b0;
        repeat (2) @(posedge clk);
        repeat (3) tick();
        exp_state(0, 1, "pause");

        px_chk(400, 100, 1, "px_400_100");
        px_chk(399, 100, 0, "px_399_100");
        px_chk(400, 640, 0, "px_400_640");
        px_chk(403, 0,   1, "px_403_0");
        px_chk(403, 2,   1, "px_403_2");
        px_chk(403, 3,   0, "px_403_3");
        px_chk(405, 20,  1, "px_405_20");
        px_chk(405, 21,  1, "px_405_21");
        px_chk(405, 22,  0, "px_405_22");
        px_chk(480, 0,   0, "px_480_0");
        px_chk(401, 639, 1, "px_401_639");
        px_chk(402, 5,   0, "px_402_5");
        px_chk(406, 0,   0, "px_406_0");

        game_status = 1'b1;
        tick();
        exp_state(1, 1, "scroll_1");

        game_status = 1'b0;
        px_chk(403, 15, 1, "px_g1_403_15");
        px_chk(403, 14, 0, "px_g1_403_14");
        px_chk(405, 19, 1, "px_g1_405_19");
        px_chk(405, 21, 0, "px_g1_405_21");
        repeat (2) tick();
        exp_state(1, 1, "pause_hold");

        game_status = 1'b1;
        repeat (62) tick();
        exp_state(63, 1, "scroll_63");
        tick();
        exp_state(0, 1, "scroll_wrap");

        repeat (960) tick();
        exp_state(0, 2, "speed_1024");
        tick();
        exp_state(2, 2, "step_by_2");
        repeat (1023) tick();
        exp_state(0, 3, "speed_2048");
        repeat (55) tick();
        exp_state(37, 3, "pre_reset");

        @(posedge clk);
        #1;
        N_rst = 1'b1;
        b17   = 1'b1;
        exp_state(0, 1, "async_reset");
        @(posedge clk);
        #1 N_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_state(0, 1, "no_spurious");
        @(posedge clk);
        #1 b17 = 1'b0;
        @(posedge clk);

        repeat (14335) tick();
        exp_state(50, 14, "before_sat");
        tick();
        exp_state(0, 15, "reach_15");
        repeat (1024) tick();
        exp_state(0, 15, "sat_hold");

        repeat (3) @(posedge clk);
        @(negedge clk);
        if (st_q.size() != 0 || px_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", st_q.size() + px_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ground.md
GROUND -- requirements
Module: ground

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: the clock is clkdiv[0] (rising edge) and the reset is N_rst (active-high despite the name).
REQ-002 clkdiv  input  32  free-running divider bus; bit 0 is the clock, bit 17 is sampled as the scroll-tick source.
REQ-003 N_rst  input  1  asynchronous active-high reset.
REQ-004 row_addr  input  9  current VGA row (0..479 visible).
REQ-005 col_addr  input  10  current VGA column (0..639 visible).
REQ-006 game_status  input  1  1 = game running, 0 = paused/over.
REQ-007 ground_position  output  6  horizontal scroll offset of the ground texture, registered.
REQ-008 speed  output  4  scroll step per tick, registered.
REQ-009 px  output  1  ground pixel-on for (row_addr, col_addr), registered.

Function
REQ-010 The block SHALL register clkdiv[17] each clock and assert an internal tick for one clock when the registered value is 0 and the current value is 1 (rising edge).
REQ-011 On a tick with game_status=1, ground_position SHALL become (ground_position + speed) mod 64; wrap-around is silent.
REQ-012 On a tick with game_status=1, a 10-bit tick counter SHALL increment; when it wraps from 1023 to 0, speed SHALL increment by 1, saturating at 15.
REQ-013 With game_status=0, ground_position, speed and the tick counter SHALL hold their values; ticks are ignored.
REQ-014 game_status changes SHALL take effect on the next tick; no other state changes occur between ticks.
REQ-015 Texture coordinate x = (col_addr + ground_position) mod 64, computed in 10 bits then truncated to 6 bits.
REQ-016 px SHALL be computed from the current inputs and registered, so it appears one clock after row_addr/col_addr are presented.
REQ-017 px SHALL be 0 whenever col_addr >= 640 or row_addr >= 480.
REQ-018 Rows 400 and 401 form the solid ground line: px = 1 for every visible column.
REQ-019 Row 403 forms the pebble row: px = 1 when (x mod 16) < 3, else 0.
REQ-020 Row 405 forms the dash row: px = 1 when (x mod 32) is 20 or 21, else 0.
REQ-021 All other rows, including 402, 404, 406 and 407, SHALL give px = 0.
REQ-022 Texture evaluation SHALL be independent of game_status, so a paused ground remains drawn at its frozen offset.

Reset
REQ-023 While N_rst=1, asynchronously: ground_position=0, speed=1, tick counter=0, px=0, and the registered clkdiv[17] sample=0.
REQ-024 A reset asserted mid-game SHALL immediately restore the REQ-023 values; operation resumes on the first tick after release.
REQ-025 Immediately after reset release, the first sample SHALL NOT create a spurious tick if clkdiv[17] is already 1. The first capture only loads the sample register.

Verification
REQ-026 Reset test: hold N_rst=1 with any inputs -> ground_position=0, speed=1, px=0.
REQ-027 Pause test: release reset with game_status=0 and advance clkdiv across 3 rising edges of bit 17 -> ground_position stays 0 and speed stays 1.
REQ-028 Scroll test: set game_status=1 -> ground_position=1 after the 1st tick, 63 after the 63rd tick, 0 (wrap) after the 64th tick.
REQ-029 Speed test: after 1024 running ticks -> speed=2; on the next tick, ground_position advances by 2. Once speed reaches 15 it stays 15 after a further 1024 ticks.
REQ-030 Pixel test at ground_position=0, one clock after each address: (400,100)->1, (399,100)->0, (400,640)->0, (403,0)->1, (403,3)->0, (405,20)->1, (405,22)->0, (480,0)->0. At ground_position=1: (403,15)->1.
REQ-031 Mid-run reset: pulse N_rst for 1 clock with ground_position=37 and speed=3 -> both return to 0 and 1 with no clock edge needed.
